// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the segment-bus capture block.
//   seg_t     : active-low segment pattern, index 0 = segment a .. index 6 = g
//   SEG_0..SEG_F, SEG_BLANK : active-low patterns of the legal hex glyphs
//   state_t   : capture FSM state (WAIT, COUNT, HELD)
//   CNT_W     : width of the saturating stability counter
package seg7_pkg;

  typedef logic [0:6] seg_t;

  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b1100000;
  localparam seg_t SEG_C     = 7'b1110010;
  localparam seg_t SEG_D     = 7'b1000010;
  localparam seg_t SEG_E     = 7'b0110000;
  localparam seg_t SEG_F     = 7'b0111000;
  localparam seg_t SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    COUNT = 2'd1,
    HELD  = 2'd2
  } state_t;

  localparam int CNT_W = 8;

endpackage

// File: rtl/seg7_encoder.sv
// seg7_encoder: combinational active-low segment pattern -> hex nibble.
//   seg : active-low pattern (index 0 = a .. 6 = g)
//   nib : encoded nibble, 0 when the pattern is not a legal glyph
//   err : 1 when the pattern is not one of the 16 hex glyphs (blank included)
module seg7_encoder
  import seg7_pkg::*;
(
  input  seg_t       seg,
  output logic [3:0] nib,
  output logic       err
);

  always_comb begin
    nib = 4'h0;
    err = 1'b0;
    case (seg)
      SEG_0:   nib = 4'h0;
      SEG_1:   nib = 4'h1;
      SEG_2:   nib = 4'h2;
      SEG_3:   nib = 4'h3;
      SEG_4:   nib = 4'h4;
      SEG_5:   nib = 4'h5;
      SEG_6:   nib = 4'h6;
      SEG_7:   nib = 4'h7;
      SEG_8:   nib = 4'h8;
      SEG_9:   nib = 4'h9;
      SEG_A:   nib = 4'hA;
      SEG_B:   nib = 4'hB;
      SEG_C:   nib = 4'hC;
      SEG_D:   nib = 4'hD;
      SEG_E:   nib = 4'hE;
      SEG_F:   nib = 4'hF;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: snoops a scanned, active-low 7-segment bus and rebuilds
// the displayed multi-digit hex value once each digit pattern is stable.
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   seg_n[0:6]  : active-low segments, index 0 = a .. 6 = g
//   an_n        : active-low digit enables, bit i selects digit i
//   value       : captured nibbles, digit i at value[4i+3:4i]
//   digit_err   : bit i set when digit i's last capture was not a hex glyph
//   frame_valid : one-cycle pulse when every digit has been captured
// Optional build macro SEG7_DP_EN adds:
//   seg_dp_n    : active-low decimal point, part of the stability compare
//   dp          : active-high decimal point per digit, written at capture
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:6]            seg_n,
`ifdef SEG7_DP_EN
  input  logic                  seg_dp_n,
  output logic [DIGITS-1:0]     dp,
`endif
  input  logic [DIGITS-1:0]     an_n,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_valid
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // Exactly one enable low: the bus is showing a single, well-defined digit.
  function automatic logic one_low(input logic [DIGITS-1:0] a);
    logic [DIGITS-1:0] s;
    s = ~a;
    return (s != '0) && ((s & (s - DIGITS'(1))) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] onehot_idx(input logic [DIGITS-1:0] sel);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Stage p0: raw bus sample, loaded every edge
  logic [DIGITS-1:0] an_p0;
  seg_t              seg_p0;
`ifdef SEG7_DP_EN
  logic              dp_p0;
  logic              same;
  assign same = ({an_n, seg_n, seg_dp_n} == {an_p0, seg_p0, dp_p0});
`else
  logic              same;
  assign same = ({an_n, seg_n} == {an_p0, seg_p0});
`endif

  always_ff @(posedge clk) begin
    an_p0  <= an_n;
    seg_p0 <= seg_n;
`ifdef SEG7_DP_EN
    dp_p0  <= seg_dp_n;
`endif
  end

  // Stage p1: stability FSM and capture into the digit slots
  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              cap;
  logic              qual_in;
  logic [3:0]        nib;
  logic              err;
  logic [IDX_W-1:0]  idx;
  logic [DIGITS-1:0] seen;
  logic [DIGITS-1:0] seen_upd;

  assign qual_in  = one_low(an_n);
  assign idx      = onehot_idx(~an_p0);
  assign seen_upd = seen | ~an_p0;

  seg7_encoder u_enc (
    .seg (seg_p0),
    .nib (nib),
    .err (err)
  );

  // A changed but still qualified input is the first edge of a new run, so
  // it restarts at count 1 rather than spending an edge in WAIT. The encoder
  // reads the p0 sample, which equals the live input whenever cap is set.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap       = 1'b0;
    case (state)
      WAIT: begin
        if (qual_in) begin
          state_nxt = COUNT;
          cnt_nxt   = CNT_W'(1);
        end else begin
          cnt_nxt   = '0;
        end
      end
      COUNT: begin
        if (qual_in && same) begin
          cnt_nxt = sat_inc(cnt);
          if (sat_inc(cnt) == STABLE_C) begin
            cap       = 1'b1;
            state_nxt = HELD;
          end
        end else if (qual_in) begin
          cnt_nxt   = CNT_W'(1);
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end
      end
      HELD: begin
        if (qual_in && same) begin
          cnt_nxt   = sat_inc(cnt);
        end else if (qual_in) begin
          state_nxt = COUNT;
          cnt_nxt   = CNT_W'(1);
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = WAIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Completing the set clears seen on the same edge as the pulse, so a
  // recapture of an already-seen digit never pulses on its own.
  always_ff @(posedge clk) begin
    if (reset) begin
      value       <= '0;
      digit_err   <= '0;
      seen        <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (cap) begin
        value[4*int'(idx) +: 4] <= nib;
        digit_err[idx]          <= err;
        if (&seen_upd) begin
          seen        <= '0;
          frame_valid <= 1'b1;
        end else begin
          seen        <= seen_upd;
        end
      end
    end
  end

`ifdef SEG7_DP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      dp <= '0;
    end else if (cap) begin
      dp[idx] <= ~dp_p0;
    end
  end
`endif

endmodule

// File: tb/tb_seg7_scan_capture.sv
module tb_seg7_scan_capture;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:6]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] value;
  logic [3:0]  digit_err;
  logic        frame_valid;

  seg7_scan_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .value       (value),
    .digit_err   (digit_err),
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Glyph table: index = nibble, entry = active-low pattern a..g
  logic [0:6] pat [16];
  initial pat = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                  7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                  7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000};

  function automatic bit legal(input logic [0:6] s);
    for (int k = 0; k < 16; k++) if (pat[k] == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] nib_of(input logic [0:6] s);
    for (int k = 0; k < 16; k++) if (pat[k] == s) return 4'(k);
    return 4'h0;
  endfunction

  function automatic int dig_of(input logic [3:0] an);
    for (int k = 0; k < DIGITS; k++) if (!an[k]) return k;
    return 0;
  endfunction

  // Length of the run of identical, single-digit-enabled samples ending now.
  function automatic int run_next(input int run, input logic [10:0] prev, input logic [10:0] cur);
    if ($countones(~cur[10:7]) != 1) return 0;
    if (run > 0 && cur == prev) return (run >= 255) ? 255 : run + 1;
    return 1;
  endfunction

  function automatic logic [15:0] put_nib(input logic [15:0] v, input int d, input logic [3:0] n);
    logic [15:0] r;
    r = v;
    for (int b = 0; b < 4; b++) r[4*d + b] = n[b];
    return r;
  endfunction

  // Behavioural model: capture when a run reaches exactly STABLE edges.
  int          m_run;
  logic [10:0] m_prev;
  logic [15:0] m_value;
  logic [3:0]  m_err;
  logic [3:0]  m_seen;
  logic        m_fv;

  always @(posedge clk) begin
    if (reset) begin
      m_run   <= 0;
      m_value <= '0;
      m_err   <= '0;
      m_seen  <= '0;
      m_fv    <= 1'b0;
    end else begin
      m_run <= run_next(m_run, m_prev, {an_n, seg_n});
      m_fv  <= 1'b0;
      if (run_next(m_run, m_prev, {an_n, seg_n}) == STABLE) begin
        m_value <= put_nib(m_value, dig_of(an_n), nib_of(seg_n));
        m_err[dig_of(an_n)] <= !legal(seg_n);
        if ((m_seen | (4'b1 << dig_of(an_n))) == 4'hF) begin
          m_seen <= '0;
          m_fv   <= 1'b1;
        end else begin
          m_seen <= m_seen | (4'b1 << dig_of(an_n));
        end
      end
    end
    m_prev <= {an_n, seg_n};
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("value", 32'(value), 32'(m_value));
      check("digit_err", 32'(digit_err), 32'(m_err));
      check("frame_valid", 32'(frame_valid), 32'(m_fv));
    end
  end

  // Called at a negedge; the inputs are first sampled at the next rising edge.
  task automatic hold(input logic [3:0] an, input logic [0:6] seg, input int n, output int fv_cycle);
    fv_cycle = 0;
    an_n  = an;
    seg_n = seg;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (frame_valid) fv_cycle = c;
    end
  endtask

  int fv;

  initial begin
    reset = 1'b1;
    an_n  = 4'hF;
    seg_n = 7'b1111111;
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    hold(4'hF, 7'b1111111, 5, fv);
    check("rst_value", 32'(value), 32'h0);
    check("rst_err", 32'(digit_err), 32'h0);
    check("rst_fv_idle", 32'(fv), 32'd0);

    // Scan digits 3..0 = 1, 2, A, F
    hold(4'b0111, 7'b1001111, 6, fv);
    check("scan_d3_fv", 32'(fv), 32'd0);
    hold(4'b1011, 7'b0010010, 6, fv);
    check("scan_d2_fv", 32'(fv), 32'd0);
    hold(4'b1101, 7'b0001000, 6, fv);
    check("scan_d1_fv", 32'(fv), 32'd0);
    hold(4'b1110, 7'b0111000, 6, fv);
    check("scan_d0_fv_cycle", 32'(fv), 32'd4);
    check("scan_value", 32'(value), 32'h12AF);
    check("scan_err", 32'(digit_err), 32'h0);

    // Glitch: three edges only on digit 1, then idle
    hold(4'b1101, 7'b0000110, 3, fv);
    hold(4'hF, 7'b1111111, 3, fv);
    check("glitch_value", 32'(value), 32'h12AF);

    // Blank on digit 2
    hold(4'b1011, 7'b1111111, 6, fv);
    check("blank_value", 32'(value), 32'h10AF);
    check("blank_err", 32'(digit_err), 32'b0100);

    // Two enables low: never qualified
    an_n  = 4'b1100;
    seg_n = 7'b0000000;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("two_low_cnt", 32'(dut.cnt), 32'd0);
    end
    check("two_low_value", 32'(value), 32'h10AF);

    // Partial frame discarded by reset
    hold(4'b1110, 7'b0000000, 6, fv);
    hold(4'b1101, 7'b0000100, 6, fv);
    check("pre_rst_value", 32'(value), 32'h1098);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_value", 32'(value), 32'h0);
    check("mid_rst_err", 32'(digit_err), 32'h0);
    hold(4'b1011, 7'b0100100, 6, fv);
    check("post_rst_d2_fv", 32'(fv), 32'd0);
    hold(4'b0111, 7'b0100000, 6, fv);
    check("post_rst_d3_fv", 32'(fv), 32'd0);
    hold(4'b1110, 7'b0001111, 6, fv);
    check("post_rst_d0_fv", 32'(fv), 32'd0);
    hold(4'b1101, 7'b1110010, 6, fv);
    check("post_rst_d1_fv_cycle", 32'(fv), 32'd4);
    check("post_rst_value", 32'(value), 32'h65C7);

    hold(4'hF, 7'b1111111, 3, fv);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
